// File: rtl/sodor_dmem_lsu_if.sv
// Bundles the command, dmem request/response and writeback response signals of the Sodor load/store unit.
// The LSU connects through the master modport; the core/memory environment uses the slave modport.
interface sodor_dmem_lsu_if #(
  parameter int XLEN = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_is_store;
  logic [2:0]      cmd_funct3;
  logic [XLEN-1:0] cmd_addr;
  logic [XLEN-1:0] cmd_wdata;
  logic            dmem_req_valid;
  logic [XLEN-1:0] dmem_req_bits_addr;
  logic [XLEN-1:0] dmem_req_bits_data;
  logic            dmem_req_bits_fcn;
  logic [3:0]      dmem_req_bits_mask;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_resp_bits_data;
  logic            lb_flush;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            lb_hit;

  modport master (
    input  cmd_valid, cmd_is_store, cmd_funct3, cmd_addr, cmd_wdata,
    input  dmem_resp_valid, dmem_resp_bits_data, lb_flush,
    output cmd_ready, dmem_req_valid, dmem_req_bits_addr, dmem_req_bits_data,
    output dmem_req_bits_fcn, dmem_req_bits_mask, rsp_valid, rsp_data, rsp_err, lb_hit
  );

  modport slave (
    output cmd_valid, cmd_is_store, cmd_funct3, cmd_addr, cmd_wdata,
    output dmem_resp_valid, dmem_resp_bits_data, lb_flush,
    input  cmd_ready, dmem_req_valid, dmem_req_bits_addr, dmem_req_bits_data,
    input  dmem_req_bits_fcn, dmem_req_bits_mask, rsp_valid, rsp_data, rsp_err, lb_hit
  );
endinterface

// File: rtl/sodor_dmem_lsu.sv
// Sodor data-memory load/store unit: one command at a time, single-entry load buffer,
// byte/half lane steering for stores and sign/zero extension for loads.
module sodor_dmem_lsu #(
  parameter int TIMEOUT = 15,
  parameter int XLEN    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  sodor_dmem_lsu_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       f3_q, f3_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             err_q, err_d;
  logic             hit_q, hit_d;
  logic             lb_valid_q, lb_valid_d;
  logic [XLEN-3:0]  lb_addr_q, lb_addr_d;
  logic [XLEN-1:0]  lb_data_q, lb_data_d;

  function automatic logic bad_funct3(input logic st, input logic [2:0] f3);
    if (st) return f3 > 3'b010;
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] word);
    logic [XLEN-1:0]        lane;
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [XLEN-1:0] r;
    lane = word >> {off, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b100:  r = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  r = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    err_d      = err_q;
    hit_d      = hit_q;
    lb_valid_d = lb_valid_q;
    lb_addr_d  = lb_addr_q;
    lb_data_d  = lb_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          is_store_d = bus.cmd_is_store;
          f3_d       = bus.cmd_funct3;
          addr_d     = bus.cmd_addr;
          wdata_d    = bus.cmd_wdata;
          err_d      = 1'b0;
          hit_d      = 1'b0;
          data_d     = '0;
          if (bad_funct3(bus.cmd_is_store, bus.cmd_funct3) ||
              misaligned(bus.cmd_funct3, bus.cmd_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!bus.cmd_is_store && lb_valid_q && !bus.lb_flush &&
                       (lb_addr_q == bus.cmd_addr[XLEN-1:2])) begin
            hit_d   = 1'b1;
            data_d  = load_extract(bus.cmd_funct3, bus.cmd_addr[1:0], lb_data_q);
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        state_d = WAIT;
        cnt_d   = '0;
        if (is_store_q && (lb_addr_q == addr_q[XLEN-1:2])) lb_valid_d = 1'b0;
      end
      WAIT: begin
        // A response in the final counted cycle still wins over the timeout.
        if (bus.dmem_resp_valid) begin
          state_d = RESP;
          if (!is_store_q) begin
            data_d     = load_extract(f3_q, addr_q[1:0], bus.dmem_resp_bits_data);
            lb_valid_d = 1'b1;
            lb_addr_d  = addr_q[XLEN-1:2];
            lb_data_d  = bus.dmem_resp_bits_data;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.lb_flush) lb_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      hit_q      <= 1'b0;
      lb_valid_q <= 1'b0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      err_q      <= err_d;
      hit_q      <= hit_d;
      lb_valid_q <= lb_valid_d;
      lb_addr_q  <= lb_addr_d;
      lb_data_q  <= lb_data_d;
    end
  end

  logic in_req, st_req, in_resp;
  assign in_req  = (state_q == REQ);
  assign st_req  = in_req && is_store_q;
  assign in_resp = (state_q == RESP);

  assign bus.cmd_ready           = (state_q == IDLE);
  assign bus.dmem_req_valid      = in_req;
  assign bus.dmem_req_bits_addr  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus.dmem_req_bits_fcn   = st_req;
  assign bus.dmem_req_bits_mask  = st_req ? store_mask(f3_q, addr_q[1:0]) : 4'b0000;
  assign bus.dmem_req_bits_data  = st_req ? store_lanes(f3_q, wdata_q) : '0;
  assign bus.rsp_valid           = in_resp;
  assign bus.rsp_data            = in_resp ? data_q : '0;
  assign bus.rsp_err             = in_resp && err_q;
  assign bus.lb_hit              = in_resp && hit_q;
endmodule

// File: tb/tb_sodor_dmem_lsu.sv
// Self-checking bench for sodor_dmem_lsu: directed vector table, hand-written timeout/reset
// sequences, and random commands scored against a word-memory plus load-buffer reference.
module tb_sodor_dmem_lsu;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sodor_dmem_lsu_if #(.XLEN(32)) bus ();
  sodor_dmem_lsu #(.TIMEOUT(15), .XLEN(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    bit          got;
    logic [31:0] data;
    logic        err;
    logic        hit;
    int          nreq;
    int          lat;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [3:0]  rmask;
    logic        rfcn;
  } obs_t;

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          flush;
    int          dly;
    bit          e_err;
    bit          e_hit;
    logic [31:0] e_data;
    int          e_nreq;
    logic [3:0]  e_mask;
    logic [31:0] e_wd;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] mem [int unsigned];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k = a >> 2;
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  function automatic int op_size(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit legal_f3(input bit st, input logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    int     size;
    longint v, span;
    size = op_size(f3);
    v = longint'(word >> (8 * (addr % 4)));
    if (size < 4) begin
      span = longint'(1) << (8 * size);
      v = v % span;
      if (f3 < 3'd4 && v >= span / 2) v = v - span;
    end
    return v[31:0];
  endfunction

  task automatic mem_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
    for (int i = 0; i < op_size(f3); i++) begin
      logic [31:0] a, word;
      a = addr + i;
      word = mem_rd(a);
      word[8*(a%4) +: 8] = w[8*i +: 8];
      mem[a >> 2] = word;
    end
  endtask

  // Drive one command, play dmem (response dly cycles after the request), collect what the DUT did.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit flush, input int dly,
                        input bit silent, output obs_t o);
    int req_n = 0;
    o = '{default: 0};
    @(negedge clk);
    chk("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_is_store = st; bus.cmd_funct3 = f3;
    bus.cmd_addr = addr; bus.cmd_wdata = wdata; bus.lb_flush = flush;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin bus.cmd_valid = 1'b0; bus.lb_flush = 1'b0; end
      if (bus.dmem_req_valid) begin
        o.nreq++; req_n = n;
        o.raddr = bus.dmem_req_bits_addr; o.rdata = bus.dmem_req_bits_data;
        o.rmask = bus.dmem_req_bits_mask; o.rfcn = bus.dmem_req_bits_fcn;
      end
      if (bus.rsp_valid) begin
        o.got = 1'b1; o.lat = n; o.data = bus.rsp_data; o.err = bus.rsp_err; o.hit = bus.lb_hit;
        break;
      end
      bus.dmem_resp_valid = !silent && (req_n > 0) && (n == req_n + dly);
      bus.dmem_resp_bits_data = mem_rd({addr[31:2], 2'b00});
    end
    bus.dmem_resp_valid = 1'b0;
    if (o.got && st && !o.err) mem_store(f3, addr, wdata);
  endtask

  task automatic check_op(input string nm, input obs_t o, input obs_t e, input bit st);
    chk({nm, "_rsp_seen"}, {31'b0, o.got}, 32'd1);
    if (o.got) begin
      chk({nm, "_data"}, o.data, e.data);
      chk({nm, "_err"}, {31'b0, o.err}, {31'b0, e.err});
      chk({nm, "_hit"}, {31'b0, o.hit}, {31'b0, e.hit});
      chk({nm, "_latency"}, o.lat, e.lat);
    end
    chk({nm, "_nreq"}, o.nreq, e.nreq);
    if (e.nreq == 1 && o.nreq == 1) begin
      chk({nm, "_req_addr"}, o.raddr, e.raddr);
      chk({nm, "_req_fcn"}, {31'b0, o.rfcn}, {31'b0, e.rfcn});
      chk({nm, "_req_mask"}, {28'b0, o.rmask}, {28'b0, e.rmask});
      if (st) chk({nm, "_req_data"}, o.rdata, e.rdata);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    obs_t o, e;
    bit lbv;
    logic [31:0] lba, lbd;

    bus.cmd_valid = 0; bus.cmd_is_store = 0; bus.cmd_funct3 = 0; bus.cmd_addr = 0;
    bus.cmd_wdata = 0; bus.dmem_resp_valid = 0; bus.dmem_resp_bits_data = 0; bus.lb_flush = 0;
    mem[32'h10 >> 2] = 32'h4BB00478;

    vt.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 2, 1'b0, 1'b0, 32'h4BB00478, 1, 4'h0, 32'h0});
    vt.push_back('{1'b0, 3'd0, 32'h13, 32'h0,        1'b0, 1, 1'b0, 1'b1, 32'h0000004B, 0, 4'h0, 32'h0});
    vt.push_back('{1'b0, 3'd0, 32'h12, 32'h0,        1'b0, 1, 1'b0, 1'b1, 32'hFFFFFFB0, 0, 4'h0, 32'h0});
    vt.push_back('{1'b0, 3'd4, 32'h12, 32'h0,        1'b0, 1, 1'b0, 1'b1, 32'h000000B0, 0, 4'h0, 32'h0});
    vt.push_back('{1'b1, 3'd0, 32'h10, 32'hAB,       1'b0, 1, 1'b0, 1'b0, 32'h0,        1, 4'h1, 32'hABABABAB});
    vt.push_back('{1'b0, 3'd4, 32'h11, 32'h0,        1'b0, 1, 1'b0, 1'b0, 32'h00000004, 1, 4'h0, 32'h0});
    vt.push_back('{1'b0, 3'd1, 32'h21, 32'h0,        1'b0, 1, 1'b1, 1'b0, 32'h0,        0, 4'h0, 32'h0});
    vt.push_back('{1'b0, 3'd3, 32'h20, 32'h0,        1'b0, 1, 1'b1, 1'b0, 32'h0,        0, 4'h0, 32'h0});
    vt.push_back('{1'b1, 3'd1, 32'h22, 32'h1234ABCD, 1'b0, 2, 1'b0, 1'b0, 32'h0,        1, 4'hC, 32'hABCDABCD});
    vt.push_back('{1'b0, 3'd1, 32'h22, 32'h0,        1'b0, 1, 1'b0, 1'b0, 32'hFFFFABCD, 1, 4'h0, 32'h0});
    vt.push_back('{1'b0, 3'd5, 32'h22, 32'h0,        1'b0, 1, 1'b0, 1'b1, 32'h0000ABCD, 0, 4'h0, 32'h0});
    vt.push_back('{1'b1, 3'd3, 32'h20, 32'h55,       1'b0, 1, 1'b1, 1'b0, 32'h0,        0, 4'h0, 32'h0});
    vt.push_back('{1'b0, 3'd2, 32'h21, 32'h0,        1'b0, 1, 1'b1, 1'b0, 32'h0,        0, 4'h0, 32'h0});
    vt.push_back('{1'b0, 3'd2, 32'h20, 32'h0,        1'b1, 3, 1'b0, 1'b0, 32'hABCD0000, 1, 4'h0, 32'h0});
    vt.push_back('{1'b1, 3'd2, 32'h24, 32'hDEADBEEF, 1'b0, 1, 1'b0, 1'b0, 32'h0,        1, 4'hF, 32'hDEADBEEF});
    vt.push_back('{1'b0, 3'd1, 32'h12, 32'h0,        1'b0, 1, 1'b0, 1'b0, 32'h00004BB0, 1, 4'h0, 32'h0});
    vt.push_back('{1'b0, 3'd0, 32'h10, 32'h0,        1'b0, 1, 1'b0, 1'b1, 32'hFFFFFFAB, 0, 4'h0, 32'h0});

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("reset_req_valid", {31'b0, bus.dmem_req_valid}, 32'd0);
    chk("reset_req_mask", {28'b0, bus.dmem_req_bits_mask}, 32'd0);
    chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      run_op(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].flush, vt[i].dly, 1'b0, o);
      e = '{got: 1'b1, data: vt[i].e_data, err: vt[i].e_err, hit: vt[i].e_hit,
            nreq: vt[i].e_nreq, lat: (vt[i].e_nreq != 0) ? 2 + vt[i].dly : 1,
            raddr: {vt[i].addr[31:2], 2'b00}, rdata: vt[i].e_wd, rmask: vt[i].e_mask,
            rfcn: vt[i].st};
      check_op($sformatf("vec%0d", i), o, e, vt[i].st);
    end

    // Timeout: dmem silent, then a late response arriving in IDLE must be ignored
    run_op(1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 1, 1'b1, o);
    e = '{got: 1'b1, data: 32'h0, err: 1'b1, hit: 1'b0, nreq: 1, lat: 17,
          raddr: 32'h30, rdata: 32'h0, rmask: 4'h0, rfcn: 1'b0};
    check_op("timeout", o, e, 1'b0);
    @(negedge clk);
    bus.dmem_resp_valid = 1'b1; bus.dmem_resp_bits_data = 32'h12345678;
    @(negedge clk);
    bus.dmem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_resp_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
      chk("late_resp_idle", {31'b0, bus.cmd_ready}, 32'd1);
      @(negedge clk);
    end
    mem[32'h30 >> 2] = 32'h0BADF00D;
    run_op(1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 1, 1'b0, o);
    e = '{got: 1'b1, data: 32'h0BADF00D, err: 1'b0, hit: 1'b0, nreq: 1, lat: 3,
          raddr: 32'h30, rdata: 32'h0, rmask: 4'h0, rfcn: 1'b0};
    check_op("after_timeout", o, e, 1'b0);

    // Reset in the middle of a WAIT
    mem[32'h40 >> 2] = 32'h55AA1234;
    run_op(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 1, 1'b0, o);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_is_store = 1'b0; bus.cmd_funct3 = 3'd2; bus.cmd_addr = 32'h44;
    @(posedge clk);
    @(negedge clk); bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("midreset_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    chk("midreset_no_req", {31'b0, bus.dmem_req_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postreset_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    end
    run_op(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 1, 1'b0, o);
    e = '{got: 1'b1, data: 32'h55AA1234, err: 1'b0, hit: 1'b0, nreq: 1, lat: 3,
          raddr: 32'h40, rdata: 32'h0, rmask: 4'h0, rfcn: 1'b0};
    check_op("reset_cleared_lb", o, e, 1'b0);
    run_op(1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 2, 1'b0, o);
    e.lat = 4;
    check_op("flush_hit_candidate", o, e, 1'b0);
    run_op(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 1, 1'b0, o);
    e.lat = 1; e.hit = 1'b1; e.nreq = 0;
    check_op("refilled_hit", o, e, 1'b0);

    // Randomized commands against the reference model
    do_reset();
    lbv = 1'b0; lba = 32'h0; lbd = 32'h0;
    for (int i = 0; i < 80; i++) begin
      bit st, fl, hit;
      logic [2:0] f3;
      logic [31:0] addr, wd, word;
      int dly, size;
      st = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end
      size = op_size(f3);
      addr = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % size);
      wd = $urandom;
      fl = ($urandom_range(0, 7) == 0);
      dly = $urandom_range(1, 4);

      e = '{default: 0};
      e.got = 1'b1;
      e.err = !legal_f3(st, f3) || (addr % size != 0);
      hit = !e.err && !st && lbv && !fl && (lba == addr / 4);
      if (fl) lbv = 1'b0;
      if (e.err) e.lat = 1;
      else if (hit) begin
        e.hit = 1'b1; e.lat = 1; e.data = ref_load(f3, addr, lbd);
      end else begin
        e.nreq = 1; e.lat = 2 + dly; e.raddr = addr - addr % 4; e.rfcn = st;
        if (st) begin
          e.rmask = 4'(((1 << size) - 1) << (addr % 4));
          e.rdata = (size == 1) ? (wd % 256) * 32'h01010101 :
                    (size == 2) ? (wd % 65536) * 32'h00010001 : wd;
          if (lba == addr / 4) lbv = 1'b0;
        end else begin
          word = mem_rd(addr);
          e.data = ref_load(f3, addr, word);
          lbv = 1'b1; lba = addr / 4; lbd = word;
        end
      end
      run_op(st, f3, addr, wd, fl, dly, 1'b0, o);
      check_op($sformatf("rnd%0d", i), o, e, st);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
